// File: rtl/n64_cmd_tx.sv
// n64_cmd_tx: multi-byte transmitter for the N64 controller one-wire bus.
//
// Latches a frame of 1..MAX_BYTES bytes on a start strobe and sends it using
// pulse-width encoding: every bit is T_BIT cycles long, and the line is held
// low for T_LOW1 cycles (bit '1') or T_LOW0 cycles (bit '0'). Byte 0
// (frame[7:0]) is sent first, each byte MSB first. The frame ends with a stop
// bit (T_STOP_LOW low, T_STOP total).
//
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset; releases the line at once
//   start      single-cycle request, honoured only when idle
//   num_bytes  frame length in bytes, sampled with start
//   frame      payload, sampled with start
//   abort      synchronous cancel of a frame in progress
//   data_out   bus level (1 = released/high)
//   drive_low  pad output-enable, always ~data_out
//   busy       frame in progress
//   done       one-cycle pulse on normal completion (first idle cycle)
//   err        one-cycle pulse after a start with an illegal num_bytes
module n64_cmd_tx #(
    parameter int unsigned MAX_BYTES  = 4,
    parameter int unsigned T_LOW0     = 300,
    parameter int unsigned T_LOW1     = 100,
    parameter int unsigned T_BIT      = 400,
    parameter int unsigned T_STOP_LOW = 100,
    parameter int unsigned T_STOP     = 300
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             start,
    input  logic [$clog2(MAX_BYTES+1)-1:0]   num_bytes,
    input  logic [8*MAX_BYTES-1:0]           frame,
    input  logic                             abort,
    output logic                             data_out,
    output logic                             drive_low,
    output logic                             busy,
    output logic                             done,
    output logic                             err
);

    localparam int unsigned NW    = $clog2(MAX_BYTES + 1);
    localparam int unsigned T_MAX = (T_BIT > T_STOP) ? T_BIT : T_STOP;
    localparam int unsigned CW    = $clog2(T_MAX + 1);
    localparam int unsigned BW    = $clog2(8 * MAX_BYTES);
    localparam int unsigned LW    = NW + 3;

    localparam logic [CW-1:0] LowZeroEnd = CW'(T_LOW0 - 1);
    localparam logic [CW-1:0] LowOneEnd  = CW'(T_LOW1 - 1);
    localparam logic [CW-1:0] BitEnd     = CW'(T_BIT - 1);
    localparam logic [CW-1:0] StopLowEnd = CW'(T_STOP_LOW - 1);
    localparam logic [CW-1:0] StopEnd    = CW'(T_STOP - 1);

    typedef enum logic [2:0] {
        StIdle,
        StLow,
        StHigh,
        StStopLow,
        StStopHigh
    } state_e;

    state_e                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [BW-1:0]          bit_q, bit_d;
    logic [NW-1:0]          nb_q, nb_d;
    logic [8*MAX_BYTES-1:0] frame_q, frame_d;
    logic                   data_out_q, data_out_d;
    logic                   drive_low_q;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   err_q, err_d;

    logic                   num_ok;
    logic                   cur_bit;
    logic [LW-1:0]          last_idx;
    logic [CW-1:0]          low_end;

    assign num_ok   = (num_bytes != '0) && (num_bytes <= NW'(MAX_BYTES));
    // Within a byte the bit order is reversed: flipping the low three index
    // bits maps bit i onto frame[8*(i/8) + 7 - i%8].
    assign cur_bit  = frame_q[bit_q ^ BW'(7)];
    assign last_idx = {nb_q, 3'b000} - LW'(1);
    assign low_end  = cur_bit ? LowOneEnd : LowZeroEnd;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        nb_d    = nb_q;
        frame_d = frame_q;
        done_d  = 1'b0;
        err_d   = 1'b0;

        if (abort) begin
            // Abort wins over everything, including a start in the same cycle.
            state_d = StIdle;
            cnt_d   = '0;
            bit_d   = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        if (num_ok) begin
                            state_d = StLow;
                            cnt_d   = '0;
                            bit_d   = '0;
                            nb_d    = num_bytes;
                            frame_d = frame;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
                StLow: begin
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == low_end) begin
                        state_d = StHigh;
                    end
                end
                StHigh: begin
                    if (cnt_q == BitEnd) begin
                        cnt_d = '0;
                        if (LW'(bit_q) == last_idx) begin
                            state_d = StStopLow;
                        end else begin
                            bit_d   = bit_q + BW'(1);
                            state_d = StLow;
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                StStopLow: begin
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == StopLowEnd) begin
                        state_d = StStopHigh;
                    end
                end
                StStopHigh: begin
                    if (cnt_q == StopEnd) begin
                        state_d = StIdle;
                        cnt_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end

        // Outputs are decoded from the next state so they can be registered
        // without adding a cycle of latency.
        data_out_d = (state_d == StIdle) || (state_d == StHigh) || (state_d == StStopHigh);
        busy_d     = (state_d != StIdle);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            bit_q       <= '0;
            nb_q        <= '0;
            frame_q     <= '0;
            data_out_q  <= 1'b1;
            drive_low_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            nb_q        <= nb_d;
            frame_q     <= frame_d;
            data_out_q  <= data_out_d;
            drive_low_q <= ~data_out_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign data_out  = data_out_q;
    assign drive_low = drive_low_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_n64_cmd_tx.sv
// Scoreboard bench for n64_cmd_tx. Stimulus pushes the expected outcome of
// each request (full frame waveform, rejection, or truncated abort) into a
// queue; a monitor records the line while busy and checks it when busy falls
// or err pulses.
module tb_n64_cmd_tx;

    localparam int MAXB = 4;
    localparam int TL0  = 6;
    localparam int TL1  = 2;
    localparam int TB   = 8;
    localparam int TSL  = 2;
    localparam int TS   = 6;

    localparam int K_FRAME = 0;
    localparam int K_ERR   = 1;
    localparam int K_ABORT = 2;

    typedef struct {
        int           kind;
        int           len;
        int           cut;
        logic [511:0] wave;
    } exp_t;

    exp_t sb[$];

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [2:0]  num_bytes = '0;
    logic [31:0] frame = '0;
    logic        data_out, drive_low, busy, done, err;

    int n_vec = 0;
    int n_err = 0;

    logic [511:0] cap;
    int           cap_len = 0;
    bit           prev_busy = 1'b0;
    int           dl_bad = 0;

    n64_cmd_tx #(
        .MAX_BYTES (MAXB),
        .T_LOW0    (TL0),
        .T_LOW1    (TL1),
        .T_BIT     (TB),
        .T_STOP_LOW(TSL),
        .T_STOP    (TS)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .num_bytes(num_bytes),
        .frame    (frame),
        .abort    (abort),
        .data_out (data_out),
        .drive_low(drive_low),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    task automatic check(input bit ok, input string name, input longint act, input longint exp);
        n_vec++;
        if (!ok) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference waveform: each bit is TB cycles, low for TL1 ('1') or TL0 ('0').
    function automatic void build(input int nb, input logic [31:0] fr,
                                  output logic [511:0] w, output int len);
        logic [7:0] by;
        int lo;
        w   = '1;
        len = 0;
        for (int i = 0; i < 8 * nb; i++) begin
            by = fr[8*(i/8) +: 8];
            lo = by[7 - (i % 8)] ? TL1 : TL0;
            for (int c = 0; c < TB; c++) begin
                w[len] = (c >= lo);
                len++;
            end
        end
        for (int c = 0; c < TS; c++) begin
            w[len] = (c >= TSL);
            len++;
        end
    endfunction

    task automatic cmp_wave(input logic [511:0] w, input int n, input string name);
        int bad;
        bad = -1;
        for (int i = 0; i < n && i < 512; i++) begin
            if (bad < 0 && cap[i] !== w[i]) bad = i;
        end
        check(bad < 0, name, bad, -1);
    endtask

    // Monitor: samples on the inactive edge.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            cap_len   = 0;
            prev_busy = 1'b0;
            dl_bad    = 0;
        end else begin
            if (drive_low !== ~data_out) dl_bad++;
            if (busy === 1'b1) begin
                if (cap_len < 512) cap[cap_len] = data_out;
                cap_len++;
            end
            if (err === 1'b1) begin
                check(sb.size() != 0, "err_unexpected", sb.size(), 1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check(e.kind == K_ERR, "err_kind", e.kind, K_ERR);
                    check(busy === 1'b0 && data_out === 1'b1, "err_idle_line",
                          {busy, data_out}, 2'b01);
                end
            end
            if (prev_busy && busy === 1'b0) begin
                check(sb.size() != 0, "end_unexpected", sb.size(), 1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    if (done === 1'b1) begin
                        check(e.kind == K_FRAME, "done_kind", K_FRAME, e.kind);
                        check(cap_len == e.len, "busy_len", cap_len, e.len);
                        cmp_wave(e.wave, e.len, "frame_wave_first_bad_cycle");
                    end else begin
                        check(e.kind == K_ABORT, "end_without_done_kind", K_ABORT, e.kind);
                        check(cap_len == e.cut, "abort_busy_len", cap_len, e.cut);
                        cmp_wave(e.wave, e.cut, "abort_wave_first_bad_cycle");
                    end
                    check(dl_bad == 0, "drive_low_vs_data_out", dl_bad, 0);
                end
                cap_len = 0;
                dl_bad  = 0;
            end else if (done === 1'b1) begin
                check(1'b0 == done, "spurious_done", done, 0);
            end
            prev_busy = (busy === 1'b1);
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (done !== 1'b1 && n < 400) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(done === 1'b1, "done_timeout", done, 1);
    endtask

    // Issue one request; cut > 0 aborts after that many busy cycles.
    task automatic launch(input int nb, input logic [31:0] fr, input int cut);
        exp_t e;
        bit   ok_nb;
        ok_nb  = (nb >= 1 && nb <= MAXB);
        e.kind = !ok_nb ? K_ERR : (cut > 0 ? K_ABORT : K_FRAME);
        e.cut  = cut;
        e.wave = '1;
        e.len  = 0;
        if (ok_nb) build(nb, fr, e.wave, e.len);
        sb.push_back(e);
        start     = 1'b1;
        num_bytes = 3'(nb);
        frame     = fr;
        @(posedge clk);
        #1;
        start     = 1'b0;
        frame     = $urandom;
        num_bytes = 3'($urandom);
        if (ok_nb) begin
            check(busy === 1'b1 && data_out === 1'b0 && err === 1'b0, "start_latency",
                  {busy, data_out, err}, 3'b100);
        end else begin
            check(err === 1'b1 && busy === 1'b0 && data_out === 1'b1, "reject",
                  {err, busy, data_out}, 3'b101);
            @(posedge clk);
            #1;
            check(err === 1'b0, "err_width", err, 0);
        end
        if (ok_nb && cut > 0) begin
            repeat (cut - 1) @(posedge clk);
            #1 abort = 1'b1;
            @(posedge clk);
            #1 abort = 1'b0;
            check(busy === 1'b0 && data_out === 1'b1 && drive_low === 1'b0 && done === 1'b0,
                  "abort_release", {busy, data_out, drive_low, done}, 4'b0100);
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check(data_out === 1'b1, "rst_data_out", data_out, 1);
        check(drive_low === 1'b0, "rst_drive_low", drive_low, 0);
        check(busy === 1'b0, "rst_busy", busy, 0);
        check(done === 1'b0, "rst_done", done, 0);
        check(err === 1'b0, "rst_err", err, 0);
        #1 rst_n = 1'b1;
        idle(2);

        // Single byte, then four bytes started in the done cycle.
        launch(1, 32'h0000_0001, 0);
        wait_done();
        launch(4, 32'hA5C3_0FF0, 0);
        wait_done();
        idle(2);

        // Rejected lengths.
        launch(0, $urandom, 0);
        idle(2);
        launch(5, $urandom, 0);
        idle(2);

        // Abort and start together in idle: nothing happens.
        start = 1'b1;
        abort = 1'b1;
        num_bytes = 3'd2;
        @(posedge clk);
        #1;
        start = 1'b0;
        abort = 1'b0;
        check(busy === 1'b0 && err === 1'b0 && data_out === 1'b1, "abort_beats_start",
              {busy, err, data_out}, 3'b001);
        idle(2);

        // Abort at cycle 20 of a 2-byte frame, then a normal frame.
        launch(2, $urandom, 20);
        idle(3);
        launch(2, $urandom, 0);
        wait_done();
        idle(2);

        // Reset during a LOW phase: line released without a clock edge.
        start = 1'b1;
        num_bytes = 3'd1;
        frame = 32'h0;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check(data_out === 1'b0, "pre_reset_low", data_out, 0);
        #1 rst_n = 1'b0;
        #1;
        check(data_out === 1'b1 && drive_low === 1'b0 && busy === 1'b0, "async_reset",
              {data_out, drive_low, busy}, 3'b100);
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check(busy === 1'b0 && done === 1'b0 && err === 1'b0 && data_out === 1'b1 &&
              drive_low === 1'b0, "post_reset", {busy, done, err, data_out, drive_low}, 5'b00010);
        idle(2);

        // Payload immunity while busy, then back-to-back frame.
        launch(2, 32'h0000_3CA5, 0);
        repeat (30) @(posedge clk);
        #1;
        frame = $urandom;
        num_bytes = 3'd3;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        check(err === 1'b0 && busy === 1'b1, "start_while_busy", {err, busy}, 2'b01);
        wait_done();
        launch(3, $urandom, 0);
        wait_done();

        // Randomized traffic.
        for (int it = 0; it < 30; it++) begin
            int nb;
            int cut;
            nb  = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 7))
                                               : int'($urandom_range(1, 4));
            cut = 0;
            if (nb >= 1 && nb <= MAXB && $urandom_range(0, 3) == 0) begin
                cut = int'($urandom_range(1, 64 * nb + 6));
            end
            launch(nb, $urandom, cut);
            if (nb >= 1 && nb <= MAXB && cut == 0) begin
                wait_done();
                if ($urandom_range(0, 1) == 1) idle(int'($urandom_range(1, 3)));
            end else begin
                idle(int'($urandom_range(1, 3)));
            end
        end

        idle(5);
        check(sb.size() == 0, "scoreboard_drain", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/n64_cmd_tx.md
# n64_cmd_tx

Parametrised transmitter for the N64 controller one-wire bus, the multi-byte successor of the single-byte command writer. It latches a frame of 1..MAX_BYTES bytes on a start strobe and serialises it MSB-first, one bit per T_BIT cycles, using pulse-width encoding, then appends a console stop bit. It sits between the poll sequencer and the open-drain pad. It reports busy/done/error so the sequencer can chain a receive window directly after the stop bit.

## Interface
- MAX_BYTES, 4: largest frame in bytes (1..16).
- T_LOW0, 300: low cycles for a '0' bit (3 µs at 100 MHz).
- T_LOW1, 100: low cycles for a '1' bit (1 µs).
- T_BIT, 400: total cycles per data bit; must exceed T_LOW0 > T_LOW1 > 0.
- T_STOP_LOW, 100: low cycles of the stop bit.
- T_STOP, 300: total cycles of the stop bit; must exceed T_STOP_LOW.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle request; sampled only in IDLE.
- num_bytes  in  $clog2(MAX_BYTES+1)  frame length, sampled with start.
- frame  in  8*MAX_BYTES  payload; byte 0 = frame[7:0] is sent first, each byte MSB first.
- abort  in  1  synchronous cancel.
- data_out  out  1  bus level (1 = released/high).
- drive_low  out  1  pad output-enable, always equal to ~data_out.
- busy  out  1  frame in progress.
- done  out  1  one-cycle pulse on normal completion.
- err  out  1  one-cycle pulse on a rejected start.

## Operation
- States: IDLE, LOW, HIGH, STOP_LOW, STOP_HIGH.
- IDLE: data_out=1, busy=0. On start with 1 ≤ num_bytes ≤ MAX_BYTES: latch frame and num_bytes, clear bit counter and cycle counter, go to LOW, busy=1.
- On start with num_bytes=0 or num_bytes > MAX_BYTES: pulse err the next cycle and remain in IDLE. frame is not latched.
- LOW: data_out=0 for T_LOW1 cycles if the current bit is 1, or T_LOW0 cycles if it is 0. Then go to HIGH.
- HIGH: data_out=1 until the cycle counter reaches T_BIT since the bit began. Then:
  - if the last bit has been sent (bit index = 8*num_bytes−1), go to STOP_LOW;
  - otherwise advance the bit index and go to LOW.
- STOP_LOW: data_out=0 for T_STOP_LOW cycles, then STOP_HIGH.
- STOP_HIGH: data_out=1 until T_STOP cycles since stop began, then IDLE. done pulses and busy falls on that same transition.
- Bit order: index i selects frame[8*(i/8) + 7 − (i%8)].
- The latched payload is immune to changes on frame or num_bytes while busy. start while busy is ignored and does not raise err.
- abort while busy: next cycle is IDLE, data_out=1, busy=0, no done.
- abort in IDLE: no effect.
- abort and start asserted in the same IDLE cycle: abort wins, stays IDLE.
- Counters are sized $clog2(max(T_BIT,T_STOP)+1) and $clog2(8*MAX_BYTES) bits. No wrap may occur within a legal frame.

## Timing
- Reset values: data_out=1, drive_low=0, busy=0, done=0, err=0, state=IDLE.
- Reset is honoured mid-frame: the line is released immediately and asynchronously.
- All outputs are registered.
- start sampled at edge k: data_out=0 and busy=1 from edge k+1.
- Frame length from the first low cycle to the cycle busy falls: 8·N·T_BIT + T_STOP cycles.
- done is high exactly one cycle, coincident with the first IDLE cycle (busy=0).
- A new start is accepted in the same cycle done is high.
- Back-to-back frames therefore have no idle gap beyond one cycle.
- err is asserted at edge k+1 for a rejected start sampled at edge k.

## Test plan
Use T_LOW1=2, T_LOW0=6, T_BIT=8, T_STOP_LOW=2, T_STOP=6, MAX_BYTES=4 for all scenarios.

- Single byte: num_bytes=1, frame[7:0]=0x01.
  - Requires 7 bits of 6-low/2-high, then 1 bit of 2-low/6-high, then stop 2-low/4-high.
  - busy high for 70 cycles; one done pulse.
- Four bytes: frame=0xA5C3_0FF0, num_bytes=4.
  - Requires sequence 0xF0, 0x0F, 0xC3, 0xA5, each MSB first.
  - busy high for 262 cycles.
- Rejection:
  - num_bytes=0 -> err pulse one cycle later, busy stays 0, data_out stays 1.
  - Same for num_bytes=5.
- Abort: abort at cycle 20 of a 2-byte frame -> data_out=1 and busy=0 next cycle, done never asserts. A following start sends normally.
- Reset mid-frame: rst_n low during a LOW phase -> data_out=1 and drive_low=0 without waiting for a clock edge. All flags are 0 after release.
- Busy immunity and back-to-back:
  - frame changed and start pulsed mid-frame -> the original payload completes.
  - start in the done cycle -> the second frame's first low cycle follows immediately.
